// File: rtl/cg_rvarch_instr_pkg.sv
// RV base-ISA encodings shared by decode logic: format codes, opcode constants,
// raw field split and the XLEN-generic sign-extended immediate mux.
package CG_rvarch_instr_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // Field layout mirrors the instruction word, so a plain cast splits it.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;

  function automatic instr_fields_t split_fields(input logic [31:0] instr);
    return instr_fields_t'(instr);
  endfunction

  function automatic logic opcode_known(input logic [6:0] opc, input logic xlen64);
    logic known;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: known = 1'b1;
      OPC_OP_IMM_32, OPC_OP_32:                       known = xlen64;
      default:                                        known = 1'b0;
    endcase
    return known;
  endfunction

  // Immediate sign-extended to 64 bits; callers keep the low XLEN bits.
  function automatic logic [63:0] imm_sel(input fmt_e fmt, input logic [31:7] ins);
    logic [63:0] imm;
    case (fmt)
      FMT_I:   imm = {{52{ins[31]}}, ins[31:20]};
      FMT_S:   imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm = {{32{ins[31]}}, ins[31:12], 12'b0};
      FMT_J:   imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 64'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/cg_sync_fifo.sv
// Synchronous FIFO with registered ready, flush, and output hold while empty.
module cg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] hold_q;
  logic             ready_q, do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = i_push && ready_q;
  assign do_pop  = i_pop && (count != '0);
  assign o_valid = (count != '0);
  assign o_ready = ready_q;
  assign o_data  = o_valid ? mem[rd_ptr] : hold_q;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && do_push) mem[wr_ptr] <= i_data;
  end

  // hold_q captures the entry leaving the head so outputs stay put when empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
      hold_q  <= '0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
      if (o_valid) hold_q <= mem[rd_ptr];
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        hold_q <= mem[rd_ptr];
      end
      count   <= count_nxt;
      ready_q <= (count_nxt < CW'(DEPTH));
    end
  end

endmodule

// File: rtl/cg_rvarch_decode_stage.sv
// RV instruction decode stage: combinational decode into a DEPTH-entry FIFO.
// Optional illegal-instruction checking is enabled by CG_RVDEC_ILLEGAL_CHECK_EN.
module cg_rvarch_decode_stage
  import CG_rvarch_instr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [2:0]      o_fmt,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  localparam int WIDTH = 2 * XLEN + 36;

  instr_fields_t    f;
  fmt_e             base_fmt, dec_fmt;
  logic             dec_illegal;
  logic [63:0]      imm_full;
  logic [XLEN-1:0]  dec_imm;
  logic             unused_imm_hi;
  logic [WIDTH-1:0] wdata, rdata;

  assign f = split_fields(i_instr);

  // Unknown opcodes fall through to R, which also yields a zero immediate.
  always_comb begin
    base_fmt = FMT_R;
    case (f.opcode)
      OPC_LUI, OPC_AUIPC:  base_fmt = FMT_U;
      OPC_JAL:             base_fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM:
                           base_fmt = FMT_I;
      OPC_STORE:           base_fmt = FMT_S;
      OPC_BRANCH:          base_fmt = FMT_B;
      OPC_OP:              base_fmt = FMT_R;
      OPC_OP_IMM_32:       if (XLEN == 64) base_fmt = FMT_I;
      OPC_OP_32:           base_fmt = FMT_R;
      default:             base_fmt = FMT_R;
    endcase
  end

`ifdef CG_RVDEC_ILLEGAL_CHECK_EN
  assign dec_illegal = (i_instr[1:0] != 2'b11) || !opcode_known(f.opcode, XLEN == 64);
  assign dec_fmt     = dec_illegal ? FMT_ILL : base_fmt;
`else
  assign dec_illegal = 1'b0;
  assign dec_fmt     = base_fmt;
`endif

  assign imm_full      = imm_sel(dec_fmt, i_instr[31:7]);
  assign dec_imm       = imm_full[XLEN-1:0];
  assign unused_imm_hi = ^imm_full;

  assign wdata = {i_pc, f.opcode, f.rd, f.rs1, f.rs2, f.funct3, f.funct7,
                  dec_fmt, dec_imm, dec_illegal};

  cg_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_push  (i_valid),
    .i_data  (wdata),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_pop   (i_ready),
    .o_data  (rdata)
  );

  assign {o_pc, o_opcode, o_rd, o_rs1, o_rs2, o_funct3, o_funct7,
          o_fmt, o_imm, o_illegal} = rdata;

endmodule

// File: doc/cg_rvarch_decode_stage.md
CG_RVARCH_DECODE_STAGE -- requirements
Module: cg_rvarch_decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Reset is sampled only on the rising edge of i_clk.
REQ-002 The block SHALL have these parameters:
- XLEN, default 32, datapath width; legal values are 32 and 64.
- DEPTH, default 2, output buffer entries; legal values are 2 to 8.
REQ-003 The block SHALL have these ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_flush, input, 1, discard all buffered entries.
- i_valid, input, 1, instruction offered.
- o_ready, output, 1, block can accept.
- i_instr, input, 32, raw instruction.
- i_pc, input, XLEN, instruction address.
- o_valid, output, 1, decoded entry available.
- i_ready, input, 1, consumer accepts.
- o_pc, output, XLEN, address passed through.
- o_opcode, output, 7, opcode field.
- o_rd, o_rs1, o_rs2, output, 5 each, register fields.
- o_funct3, output, 3, funct3 field.
- o_funct7, output, 7, funct7 field.
- o_fmt, output, 3, instruction format code.
- o_imm, output, XLEN, sign-extended immediate.
- o_illegal, output, 1, instruction flagged illegal.

Function
REQ-004 A transfer in SHALL occur on an edge where i_valid and o_ready are both 1. A transfer out SHALL occur on an edge where o_valid and i_ready are both 1.
REQ-005 Decode SHALL be combinational from i_instr and i_pc. The result is written into a DEPTH-entry FIFO, so there is 1-cycle latency: an instruction accepted at edge N is visible at the outputs after edge N.
REQ-006 o_ready SHALL be registered and SHALL equal (count < DEPTH). It SHALL not depend combinationally on i_ready.
REQ-007 Buffer boundary conditions:
- Simultaneous push and pop SHALL leave count unchanged.
- When full, no push is possible.
- When empty, o_valid is 0 and the outputs hold the last value.
- Read and write pointers SHALL wrap modulo DEPTH.
REQ-008 i_flush SHALL set count to 0 and reset both pointers on the next edge. Flush has priority over a simultaneous push and pop, and the pushed data is dropped.
REQ-009 Format mapping (decode table, o_fmt):
- LUI, AUIPC -> U
- JAL -> J
- JALR, LOAD, OP-IMM, MISC-MEM, SYSTEM -> I
- STORE -> S
- BRANCH -> B
- OP -> R
- OP-IMM-32 -> I and OP-32 -> R, only when XLEN=64
REQ-010 Immediates, each sign-extended from bit 31 to XLEN:
- I = instr[31:20]
- S = {instr[31:25], instr[11:7]}
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U = {instr[31:12], 12'b0}
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- R-format: o_imm = 0
REQ-011 Register and funct fields SHALL pass through raw, regardless of format.
REQ-012 When a transfer in and a transfer out happen on the same edge with count = 1, the new entry SHALL appear after that edge with no bubble.

Reset
REQ-013 Reset SHALL have priority over flush.
REQ-014 On reset:
- count and pointers = 0, o_valid = 0, o_ready = 1.
- All data outputs = 0, o_fmt = R, o_illegal = 0.
REQ-015 Reset asserted mid-transfer SHALL discard every entry. No partial entry is emitted.

Configuration
REQ-016 With CG_RVDEC_ILLEGAL_CHECK_EN defined, o_illegal = 1 when any of these holds:
- instr[1:0] != 2'b11
- unlisted opcode
- a 64-bit-only opcode with XLEN=32
In the illegal case, o_fmt = ILL and o_imm = 0.
REQ-017 Without CG_RVDEC_ILLEGAL_CHECK_EN:
- o_illegal SHALL be constant 0.
- An unknown opcode decodes as R with o_imm = 0.
- No check logic is synthesised.

Structure
REQ-018 The o_fmt enum SHALL live in the shared package CG_rvarch_instr_pkg: R = 0, I = 1, S = 2, B = 3, U = 4, J = 5, ILL = 7.
REQ-019 The 7-bit opcode constants SHALL also live in CG_rvarch_instr_pkg.
REQ-020 Field and immediate extraction SHALL use the package functions. The XLEN-generic immediate mux also belongs in the package.
REQ-021 The FIFO SHALL be the sub-module cg_sync_fifo (WIDTH, DEPTH), instantiated once. The decode logic stays in this module.

Verification
REQ-022 Case: XLEN=32, instr 0xFFF00093 (addi x1, x0, -1), pc 0x100.
- Response after one edge: o_fmt = I, o_rd = 1, o_imm = 0xFFFFFFFF, o_pc = 0x100.
REQ-023 Case: XLEN=64, instr 0x800000EF (jal with negative offset).
- Response: o_fmt = J, o_imm = 0xFFFFFFFFFFF00000.
REQ-024 Case: DEPTH=2, i_ready held 0, three back-to-back valid pushes.
- Response: o_ready falls after the 2nd accepted push and the 3rd is not accepted.
- Then i_ready = 1: outputs emerge in order with no loss or duplication.
REQ-025 Case: buffer holding 2 entries, i_flush pulsed with i_valid = 1.
- Response next cycle: o_valid = 0, o_ready = 1, and the pushed instruction is discarded.
REQ-026 Case: with CG_RVDEC_ILLEGAL_CHECK_EN, XLEN=32, instr 0x0000003B (OP-32).
- With the macro: o_illegal = 1, o_fmt = 7.
- Without the macro: o_illegal = 0, o_fmt = R.
REQ-027 Case: reset asserted for 1 cycle while o_valid = 1.
- Response: o_valid = 0 and o_ready = 1 on the following cycle.
